// File: rtl/cpu_bus_pkg.sv
// Shared bus widths, field offsets and load-op encodings for the EX/MEM/WB/ID
// pipeline buses of the LoongArch core.
package cpu_bus_pkg;

  localparam int EX2MEM_W = 175;
  localparam int MEM2WB_W = 167;
  localparam int MEM2ID_W = 39;

  // ex_to_mem_bus: {mem_req_issued, load_op[4:0], addr_lo[1:0], base[166:0]}
  localparam int EX2MEM_REQ      = 174;
  localparam int EX2MEM_LOP_LSB  = 169;
  localparam int EX2MEM_ALO_LSB  = 167;
  localparam int EX2MEM_BASE_LSB = 0;

  // mem_to_wb_bus field LSBs (MSB first)
  localparam int WB_RF_WE          = 166;
  localparam int WB_WADDR_LSB      = 161;
  localparam int WB_WDATA_LSB      = 129;
  localparam int WB_PC_LSB         = 97;
  localparam int WB_CSR_RE         = 96;
  localparam int WB_CSR_WE         = 95;
  localparam int WB_CSR_NUM_LSB    = 81;
  localparam int WB_CSR_WMASK_LSB  = 49;
  localparam int WB_CSR_WVALUE_LSB = 17;
  localparam int WB_ERTN           = 16;
  localparam int WB_EXCEP          = 15;
  localparam int WB_ECODE_LSB      = 9;
  localparam int WB_ESUB_LSB       = 0;

  // mem_to_id_bus: {rf_we, rf_waddr, final_wdata, no_fwd}
  localparam int ID_WE        = 38;
  localparam int ID_WADDR_LSB = 33;
  localparam int ID_WDATA_LSB = 1;
  localparam int ID_NOFWD     = 0;

  // load_op bit indices: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  localparam int LOP_LD_B  = 4;
  localparam int LOP_LD_BU = 3;
  localparam int LOP_LD_H  = 2;
  localparam int LOP_LD_HU = 1;
  localparam int LOP_LD_W  = 0;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn_flush;
    logic        excep_en;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
  } mem2wb_t;

  typedef enum logic [1:0] {
    EXT_NONE = 2'd0,
    EXT_BYTE = 2'd1,
    EXT_HALF = 2'd2,
    EXT_WORD = 2'd3
  } ext_size_e;

  function automatic ext_size_e lop_size(input logic [4:0] lop);
    if (lop[LOP_LD_B] | lop[LOP_LD_BU]) return EXT_BYTE;
    if (lop[LOP_LD_H] | lop[LOP_LD_HU]) return EXT_HALF;
    if (lop[LOP_LD_W])                  return EXT_WORD;
    return EXT_NONE;
  endfunction

endpackage

// File: rtl/mem_load_extract.sv
// Load data extraction: selects the byte/half/word addressed by addr_lo from
// the SRAM response word and sign- or zero-extends it to 32 bits.
module mem_load_extract
  import cpu_bus_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [4:0]  load_op_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  // pick the addressed byte and half-word lanes
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sign_ext = load_op_i[LOP_LD_B] | load_op_i[LOP_LD_H];
  end

  // extend the selected lane according to the load size
  always_comb begin
    result_o = rdata_i;
    case (lop_size(load_op_i))
      EXT_BYTE: result_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      EXT_HALF: result_o = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response,
// extracts load data and forwards the result to WB, ID and EX.
// Optional macro MEM_LOAD_FWD_EN: when defined, load data is forwarded to ID in
// the cycle it arrives; otherwise ID sees no_fwd for any load still in MEM.
module mem_stage
  import cpu_bus_pkg::*;
#(
  parameter int DISCARD_W = 2
)
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_to_mem_valid,
  output logic                mem_allowin,
  input  logic [EX2MEM_W-1:0] ex_to_mem_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [MEM2WB_W-1:0] mem_to_wb_bus,
  output logic [MEM2ID_W-1:0] mem_to_id_bus,
  output logic                mem_to_ex_bus,
  input  logic                wb_flush
);

  localparam logic [DISCARD_W+1:0] DISCARD_MAX = {2'b00, {DISCARD_W{1'b1}}};

  logic                 mem_valid_q, mem_valid_d;
  mem2wb_t              base_q, base_d;
  logic [4:0]           load_op_q, load_op_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic                 mem_wait_q, mem_wait_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [DISCARD_W-1:0] discard_q, discard_d;
  logic [DISCARD_W+1:0] discard_sum;

  logic                 ex_req;
  logic [4:0]           ex_load_op;
  logic [1:0]           ex_addr_lo;
  mem2wb_t              ex_base;

  logic                 data_ok_eff;
  logic                 ready_go;
  logic                 accept;
  logic                 is_load;
  logic                 ld_pending;
  logic                 no_fwd;
  logic                 inc_held, inc_new, dec;
  logic [31:0]          ld_rdata;
  logic [31:0]          ld_value;
  logic [31:0]          final_wdata;
  mem2wb_t              wb_out;

  assign ex_req     = ex_to_mem_bus[EX2MEM_REQ];
  assign ex_load_op = ex_to_mem_bus[EX2MEM_LOP_LSB +: 5];
  assign ex_addr_lo = ex_to_mem_bus[EX2MEM_ALO_LSB +: 2];
  assign ex_base    = ex_to_mem_bus[EX2MEM_BASE_LSB +: MEM2WB_W];

  // A response counts only once every stale response owed to flushed
  // instructions has been swallowed.
  assign data_ok_eff = data_sram_data_ok & (discard_q == '0);
  assign ready_go    = ~mem_wait_q | data_ok_eff;
  // The held instruction is dead during a flush, so the slot is free to take
  // (and immediately drop) whatever EX presents; its request is then counted
  // as stale.
  assign mem_allowin = ~mem_valid_q | (ready_go & wb_allowin) | wb_flush;
  assign accept      = ex_to_mem_valid & mem_allowin;

  assign is_load  = |load_op_q;
  // Live response while still waiting, otherwise the copy captured earlier.
  assign ld_rdata = mem_wait_q ? data_sram_rdata : rdata_q;

  mem_load_extract u_extract (
    .rdata_i   (ld_rdata),
    .addr_lo_i (addr_lo_q),
    .load_op_i (load_op_q),
    .result_o  (ld_value)
  );

  assign final_wdata = is_load ? ld_value : base_q.rf_wdata;

  // next-state for the instruction slot, wait flag and captured load data
  always_comb begin
    mem_valid_d = mem_valid_q;
    base_d      = base_q;
    load_op_d   = load_op_q;
    addr_lo_d   = addr_lo_q;
    mem_wait_d  = mem_wait_q;
    rdata_d     = rdata_q;

    if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid & ~wb_flush;
    end
    if (accept) begin
      base_d    = ex_base;
      load_op_d = ex_load_op;
      addr_lo_d = ex_addr_lo;
    end
    if (mem_allowin) begin
      mem_wait_d = accept & ex_req & ~wb_flush;
    end else if (data_ok_eff) begin
      mem_wait_d = 1'b0;
    end
    if (mem_wait_q & data_ok_eff & ~mem_allowin) begin
      rdata_d = data_sram_rdata;
    end
  end

  // stale-response bookkeeping: requests orphaned by a flush are counted and
  // their responses swallowed in order
  always_comb begin
    inc_held    = wb_flush & mem_valid_q & mem_wait_q & ~data_ok_eff;
    inc_new     = wb_flush & accept & ex_req;
    dec         = data_sram_data_ok & (discard_q != '0);
    discard_sum = {2'b00, discard_q}
                + (DISCARD_W+2)'(inc_held)
                + (DISCARD_W+2)'(inc_new)
                - (DISCARD_W+2)'(dec);
    if (discard_sum > DISCARD_MAX) begin
      discard_d = DISCARD_MAX[DISCARD_W-1:0];
    end else begin
      discard_d = discard_sum[DISCARD_W-1:0];
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      base_q      <= '0;
      load_op_q   <= '0;
      addr_lo_q   <= '0;
      mem_wait_q  <= 1'b0;
      rdata_q     <= '0;
      discard_q   <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      base_q      <= base_d;
      load_op_q   <= load_op_d;
      addr_lo_q   <= addr_lo_d;
      mem_wait_q  <= mem_wait_d;
      rdata_q     <= rdata_d;
      discard_q   <= discard_d;
    end
  end

  // more outstanding stale responses than the counter can hold is a design error
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (discard_sum <= DISCARD_MAX);
    end
  end

  // WB payload: loaded/ALU data, and no register write for an excepting instruction
  always_comb begin
    wb_out          = base_q;
    wb_out.rf_we    = base_q.rf_we & ~base_q.excep_en;
    wb_out.rf_wdata = final_wdata;
  end

`ifdef MEM_LOAD_FWD_EN
  assign ld_pending = is_load & mem_wait_q & ~data_ok_eff;
`else
  assign ld_pending = is_load;
`endif

  assign no_fwd = mem_valid_q & (base_q.csr_re | ld_pending);

  assign mem_to_wb_valid = mem_valid_q & ready_go;
  assign mem_to_wb_bus   = wb_out;
  assign mem_to_id_bus   = {wb_out.rf_we & mem_valid_q, wb_out.rf_waddr, final_wdata, no_fwd};
  assign mem_to_ex_bus   = mem_valid_q & (base_q.excep_en | base_q.ertn_flush);

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic checked
// against a one-slot transaction model with an in-order SRAM response queue.
module tb_mem_stage;
  import cpu_bus_pkg::*;

  logic                clk = 1'b0;
  logic                resetn;
  logic                ex_to_mem_valid;
  logic                mem_allowin;
  logic [EX2MEM_W-1:0] ex_to_mem_bus;
  logic                data_sram_data_ok;
  logic [31:0]         data_sram_rdata;
  logic                wb_allowin;
  logic                mem_to_wb_valid;
  logic [MEM2WB_W-1:0] mem_to_wb_bus;
  logic [MEM2ID_W-1:0] mem_to_id_bus;
  logic                mem_to_ex_bus;
  logic                wb_flush;

  always #5 clk = ~clk;

  mem_stage #(.DISCARD_W(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .mem_allowin       (mem_allowin),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id_bus     (mem_to_id_bus),
    .mem_to_ex_bus     (mem_to_ex_bus),
    .wb_flush          (wb_flush)
  );

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          ready;
  } resp_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    next_id = 0;
  resp_t rq[$];

  // model of the single MEM slot
  bit           held_v = 0;
  int           held_id = -1;
  bit           held_req, held_arr, held_load, held_csr, held_xe;
  logic [166:0] held_bus;

  logic [31:0]  next_rdata;
  int           next_delay;

  task automatic check(input string tag, input logic [166:0] got, input logic [166:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [4:0] lop, input logic [1:0] alo,
                                          input logic [31:0] d);
    logic [31:0] v;
    if (lop == 5'b00001) return d;
    if (lop[4] || lop[3]) begin
      v = (d >> (8 * alo)) & 32'hFF;
      if (lop[4] && v >= 128) v = v - 256;
      return v;
    end
    v = (d >> (16 * alo[1])) & 32'hFFFF;
    if (lop[2] && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [174:0] mk_instr(input logic req, input logic [4:0] lop,
      input logic [1:0] alo, input logic we, input logic [4:0] wa, input logic [31:0] alu,
      input logic csr_re, input logic ertn, input logic exc, input logic [5:0] ecode);
    logic [191:0] r;
    mem2wb_t      b;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = r[166:0];
    b.rf_we      = we;
    b.rf_waddr   = wa;
    b.rf_wdata   = alu;
    b.csr_re     = csr_re;
    b.ertn_flush = ertn;
    b.excep_en   = exc;
    b.ecode      = ecode;
    return {req, lop, alo, b};
  endfunction

  task automatic drive_idle();
    ex_to_mem_valid   = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    wb_allowin        = 1'b1;
    wb_flush          = 1'b0;
  endtask

  // compare outputs for the current cycle, then advance the model and the clock
  task automatic step();
    logic         arriving, ready, exp_allowin, usable, nofwd;
    logic [174:0] ib;
    mem2wb_t      ibase;
    int           id, rdy;
    #1;
    arriving = data_sram_data_ok && rq.size() > 0 && held_v && rq[0].owner == held_id;
    ready = held_v && (!held_req || held_arr || arriving);
    exp_allowin = !held_v || (ready && wb_allowin) || wb_flush;
    check("allowin", 167'(mem_allowin), 167'(exp_allowin));
    check("wb_valid", 167'(mem_to_wb_valid), 167'(ready));
    check("ex_bus", 167'(mem_to_ex_bus), 167'(held_v && held_xe));
    if (ready && wb_allowin && mem_to_wb_valid)
      check("wb_bus", mem_to_wb_bus, held_bus);
`ifdef MEM_LOAD_FWD_EN
    usable = held_arr || arriving;
`else
    usable = 1'b0;
`endif
    nofwd = held_v && (held_csr || (held_load && !usable));
    check("no_fwd", 167'(mem_to_id_bus[0]), 167'(nofwd));
    check("id_we", 167'(mem_to_id_bus[38]), 167'(held_v && held_bus[166]));
    if (held_v && (!held_load || held_arr || arriving))
      check("id_data", 167'(mem_to_id_bus[37:1]), 167'(held_bus[165:129]));

    if (data_sram_data_ok && rq.size() > 0) begin
      if (arriving) held_arr = 1;
      void'(rq.pop_front());
    end
    if ((ready && wb_allowin) || wb_flush) held_v = 0;
    if (exp_allowin && ex_to_mem_valid) begin
      ib = ex_to_mem_bus;
      id = next_id++;
      if (ib[174]) begin
        rdy = cyc + 1 + next_delay;
        if (rq.size() > 0 && rq[$].ready > rdy) rdy = rq[$].ready;
        rq.push_back('{id, next_rdata, rdy});
      end
      if (!wb_flush) begin
        ibase     = ib[166:0];
        held_v    = 1;
        held_id   = id;
        held_req  = ib[174];
        held_arr  = 0;
        held_load = |ib[173:169];
        held_csr  = ibase.csr_re;
        held_xe   = ibase.excep_en | ibase.ertn_flush;
        if (held_load) ibase.rf_wdata = ref_ext(ib[173:169], ib[168:167], next_rdata);
        ibase.rf_we = ibase.rf_we & ~ibase.excep_en;
        held_bus  = ibase;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [174:0] instr);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = instr;
    step();
    ex_to_mem_valid = 1'b0;
  endtask

  task automatic respond();
    data_sram_data_ok = (rq.size() > 0);
    data_sram_rdata   = (rq.size() > 0) ? rq[0].data : $urandom;
  endtask

  task automatic rand_cycle();
    int         stale, kind;
    logic [4:0] lop;
    stale = 0;
    foreach (rq[i]) if (!(held_v && rq[i].owner == held_id)) stale++;
    kind = $urandom % 8;
    lop = 5'b00001 << ($urandom % 5);
    case (kind)
      0, 1, 2, 3: ex_to_mem_bus = mk_instr(1'b1, lop, 2'($urandom), 1'b1, 5'($urandom),
                                           $urandom, 1'b0, 1'b0, 1'b0, 6'd0);
      4: ex_to_mem_bus = mk_instr(1'b0, 5'd0, 2'($urandom), 1'($urandom), 5'($urandom),
                                  $urandom, 1'b0, 1'b0, 1'b1, 6'($urandom));
      5: ex_to_mem_bus = mk_instr(1'b0, 5'd0, 2'($urandom), 1'b0, 5'($urandom),
                                  $urandom, 1'b0, 1'b1, 1'b0, 6'd0);
      6: ex_to_mem_bus = mk_instr(1'b0, 5'd0, 2'($urandom), 1'b1, 5'($urandom),
                                  $urandom, 1'b1, 1'b0, 1'b0, 6'd0);
      default: ex_to_mem_bus = mk_instr(1'b0, 5'd0, 2'($urandom), 1'($urandom), 5'($urandom),
                                        $urandom, 1'b0, 1'b0, 1'b0, 6'd0);
    endcase
    ex_to_mem_valid   = ($urandom % 3) != 0;
    wb_allowin        = ($urandom % 4) != 0;
    wb_flush          = (stale <= 1) && (($urandom % 16) == 0);
    data_sram_data_ok = rq.size() > 0 && rq[0].ready <= cyc && ($urandom % 3) != 0;
    data_sram_rdata   = data_sram_data_ok ? rq[0].data : $urandom;
    next_rdata        = $urandom;
    next_delay        = $urandom % 4;
    step();
  endtask

  initial begin
    resetn = 1'b0;
    drive_idle();
    ex_to_mem_bus = '0;
    next_rdata = '0;
    next_delay = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_allowin", 167'(mem_allowin), 167'(1));
    check("rst_wb_valid", 167'(mem_to_wb_valid), 167'(0));
    check("rst_id_bus", 167'(mem_to_id_bus), 167'(0));
    check("rst_ex_bus", 167'(mem_to_ex_bus), 167'(0));
    step();

    // ld_b / ld_bu at addr_lo=3, response two cycles after latch
    for (int k = 0; k < 2; k++) begin
      next_rdata = 32'h80123456;
      issue(mk_instr(1'b1, (k == 0) ? 5'b10000 : 5'b01000, 2'd3, 1'b1, 5'd7, $urandom,
                     1'b0, 1'b0, 1'b0, 6'd0));
      step();
      respond();
      #1;
      check("ldb_valid", 167'(mem_to_wb_valid), 167'(1));
      check("ldb_wdata", 167'(mem_to_wb_bus[160:129]),
            167'((k == 0) ? 32'hFFFFFF80 : 32'h00000080));
      step();
      data_sram_data_ok = 1'b0;
    end

    // ld_hu at addr_lo=2 under WB backpressure
    next_rdata = 32'hBEEF1234;
    issue(mk_instr(1'b1, 5'b00010, 2'd2, 1'b1, 5'd5, $urandom, 1'b0, 1'b0, 1'b0, 6'd0));
    respond();
    wb_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ldhu_wdata", 167'(mem_to_wb_bus[160:129]), 167'(32'h0000BEEF));
      check("ldhu_hold", 167'(mem_allowin), 167'(0));
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
    end
    wb_allowin = 1'b1;
    #1;
    check("ldhu_release", 167'(mem_allowin), 167'(1));
    step();

    // flush a waiting load; its late response must be dropped
    next_rdata = 32'hAAAA5555;
    issue(mk_instr(1'b1, 5'b00001, 2'd0, 1'b1, 5'd4, $urandom, 1'b0, 1'b0, 1'b0, 6'd0));
    wb_flush = 1'b1;
    step();
    wb_flush = 1'b0;
    #1;
    check("flush_gone", 167'(mem_to_wb_valid), 167'(0));
    step();
    respond();
    #1;
    check("stale_drop", 167'(mem_to_wb_valid), 167'(0));
    step();
    data_sram_data_ok = 1'b0;
    next_rdata = 32'h13579BDF;
    issue(mk_instr(1'b1, 5'b00001, 2'd0, 1'b1, 5'd6, $urandom, 1'b0, 1'b0, 1'b0, 6'd0));
    respond();
    #1;
    check("after_flush_wdata", 167'(mem_to_wb_bus[160:129]), 167'(32'h13579BDF));
    step();
    data_sram_data_ok = 1'b0;

    // flush with a waiting load held and a new requesting load entering
    next_rdata = 32'h11111111;
    issue(mk_instr(1'b1, 5'b00001, 2'd0, 1'b1, 5'd8, $urandom, 1'b0, 1'b0, 1'b0, 6'd0));
    next_rdata = 32'h22222222;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus = mk_instr(1'b1, 5'b00001, 2'd0, 1'b1, 5'd9, $urandom, 1'b0, 1'b0, 1'b0, 6'd0);
    wb_flush = 1'b1;
    step();
    ex_to_mem_valid = 1'b0;
    wb_flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      respond();
      #1;
      check("dbl_drop", 167'(mem_to_wb_valid), 167'(0));
      step();
    end
    data_sram_data_ok = 1'b0;
    next_rdata = 32'h33333333;
    issue(mk_instr(1'b1, 5'b00001, 2'd0, 1'b1, 5'd10, $urandom, 1'b0, 1'b0, 1'b0, 6'd0));
    respond();
    #1;
    check("dbl_next_wdata", 167'(mem_to_wb_bus[160:129]), 167'(32'h33333333));
    step();
    data_sram_data_ok = 1'b0;

    // non-load add
    issue(mk_instr(1'b0, 5'd0, 2'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 1'b0, 1'b0, 6'd0));
    #1;
    check("add_valid", 167'(mem_to_wb_valid), 167'(1));
    check("add_id_bus", 167'(mem_to_id_bus), 167'({1'b1, 5'd9, 32'h1234, 1'b0}));
    step();

    // exception passes in one cycle without a register write
    issue(mk_instr(1'b0, 5'd0, 2'd0, 1'b1, 5'd3, $urandom, 1'b0, 1'b0, 1'b1, 6'h09));
    #1;
    check("exc_ex_bus", 167'(mem_to_ex_bus), 167'(1));
    check("exc_rf_we", 167'(mem_to_wb_bus[166]), 167'(0));
    check("exc_ecode", 167'(mem_to_wb_bus[14:9]), 167'(6'h09));
    check("exc_valid", 167'(mem_to_wb_valid), 167'(1));
    step();

    // randomized traffic
    repeat (3000) rand_cycle();

    // drain outstanding responses
    drive_idle();
    repeat (30) begin
      wb_allowin = 1'b1;
      respond();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
